// File: rtl/dual_port_pkg.sv
// Shared constants for the byte-enable dual-port RAM.
//   RDW_OLD / RDW_NEW : read-during-write policy selectors
//   ST_INIT / ST_RUN  : init-sweep FSM encoding
//   LANE_W            : width of one write-enable lane in bits
package dual_port_pkg;

  localparam logic RDW_OLD = 1'b0;
  localparam logic RDW_NEW = 1'b1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int LANE_W = 8;

endpackage

// File: rtl/dp_ram_core.sv
// Storage array with per-lane write enables and a registered raw read.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (clears the read register only)
//   we   : write strobe
//   wbe  : lane write enables, one bit per LANE_W slice of wd
//   wa   : write address (out-of-range writes are dropped)
//   wd   : write data
//   re   : read strobe; q updates only when re=1
//   ra   : read address (out-of-range reads return zero)
//   q    : registered read data, holds between reads; old data on collision
module dp_ram_core
  import dual_port_pkg::*;
#(
  parameter int wi  = 32,
  parameter int dep = 16,
  parameter int add = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [wi/LANE_W-1:0] wbe,
  input  logic [add-1:0]       wa,
  input  logic [wi-1:0]        wd,
  input  logic                 re,
  input  logic [add-1:0]       ra,
  output logic [wi-1:0]        q
);

  localparam int NL = wi / LANE_W;

  logic [wi-1:0] mem [dep];
  logic          wa_ok;
  logic          ra_ok;

  assign wa_ok = (int'(wa) < dep);
  assign ra_ok = (int'(ra) < dep);

  always_ff @(posedge clk) begin
    if (we && wa_ok) begin
      for (int i = 0; i < NL; i++) begin
        if (wbe[i]) begin
          mem[wa][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // ---- stage p0: raw registered read (sees pre-write contents) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (re) begin
      q <= ra_ok ? mem[ra] : '0;
    end
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, selectable
// read-during-write policy, optional output register and read-valid strobe.
// After every reset a sweep zeroes the whole array while busy is high.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   wr/be/wa/din : write request, lane enables, address, data
//   rd/ra    : read request and address
//   dout     : read data, holds between reads
//   dout_vld : one-cycle strobe marking new data on dout
//   busy     : high during reset and the init sweep
module dual_port_ram_be
  import dual_port_pkg::*;
#(
  parameter int wi       = 32,
  parameter int dep      = 16,
  parameter int add      = 4,
  parameter int rdw_mode = 0,
  parameter int out_reg  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [wi/LANE_W-1:0] be,
  input  logic [add-1:0]       wa,
  input  logic [wi-1:0]        din,
  input  logic                 rd,
  input  logic [add-1:0]       ra,
  output logic [wi-1:0]        dout,
  output logic                 dout_vld,
  output logic                 busy
);

  localparam int NL     = wi / LANE_W;
  localparam bit BYPASS = (rdw_mode == int'(RDW_NEW));

  function automatic logic [wi-1:0] merge_lanes(input logic [wi-1:0] old_w,
                                                input logic [wi-1:0] nw,
                                                input logic [NL-1:0] lane_en);
    logic [wi-1:0] r;
    r = old_w;
    for (int i = 0; i < NL; i++) begin
      if (lane_en[i]) r[i*LANE_W +: LANE_W] = nw[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  logic [0:0]     state;
  logic [add-1:0] ptr;
  logic           wr_acc;
  logic           rd_acc;
  logic           hit;

  logic           core_we;
  logic [NL-1:0]  core_be;
  logic [add-1:0] core_wa;
  logic [wi-1:0]  core_wd;

  logic [wi-1:0]  q_p0;
  logic           vld_p0;
  logic           hit_p0;
  logic [wi-1:0]  din_p0;
  logic [NL-1:0]  be_p0;
  logic [wi-1:0]  dout_p0;

  // Init sweep: one word per edge, leave INIT on the edge that clears dep-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (int'(ptr) == dep - 1) state <= ST_RUN;
    end
  end

  assign busy   = (state == ST_INIT);
  assign wr_acc = wr & ~busy;
  assign rd_acc = rd & ~busy;

  // The sweep owns the write port while busy.
  assign core_we = busy | wr_acc;
  assign core_be = busy ? '1  : be;
  assign core_wa = busy ? ptr : wa;
  assign core_wd = busy ? '0  : din;

  // Dropped out-of-range writes never bypass into a read.
  assign hit = BYPASS && rd_acc && wr_acc && (wa == ra) && (int'(wa) < dep);

  dp_ram_core #(
    .wi  (wi),
    .dep (dep),
    .add (add)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .we  (core_we),
    .wbe (core_be),
    .wa  (core_wa),
    .wd  (core_wd),
    .re  (rd_acc),
    .ra  (ra),
    .q   (q_p0)
  );

  // ---- stage p0: read strobe and collision bypass info ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      hit_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) hit_p0 <= hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      din_p0 <= din;
      be_p0  <= be;
    end
  end

  // Merge happens after the array read so the array itself stays a plain
  // read-old-data macro; all inputs are registered so dout stays stable.
  assign dout_p0 = hit_p0 ? merge_lanes(q_p0, din_p0, be_p0) : q_p0;

  generate
    if (out_reg != 0) begin : g_out_reg
      logic [wi-1:0] dout_p1;
      logic          vld_p1;

      // ---- stage p1: optional output register ----
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) dout_p1 <= dout_p0;
        end
      end

      assign dout     = dout_p1;
      assign dout_vld = vld_p1;
    end else begin : g_no_out_reg
      assign dout     = dout_p0;
      assign dout_vld = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench: dut0 = return-old / latency 1, dut1 = return-new / latency 2.
// Both share the same stimulus; a reference model pushes expected reads,
// a monitor pops them whenever dout_vld rises.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [3:0]  be;
  logic [3:0]  wa;
  logic [31:0] din;
  logic        rd;
  logic [3:0]  ra;

  logic [31:0] dout_a [2];
  logic        vld_a  [2];
  logic        busy_a [2];

  always #5 clk = ~clk;

  dual_port_ram_be #(.wi(32), .dep(16), .add(4), .rdw_mode(0), .out_reg(0)) dut0 (
    .clk(clk), .rst(rst), .wr(wr), .be(be), .wa(wa), .din(din), .rd(rd), .ra(ra),
    .dout(dout_a[0]), .dout_vld(vld_a[0]), .busy(busy_a[0])
  );

  dual_port_ram_be #(.wi(32), .dep(16), .add(4), .rdw_mode(1), .out_reg(1)) dut1 (
    .clk(clk), .rst(rst), .wr(wr), .be(be), .wa(wa), .din(din), .rd(rd), .ra(ra),
    .dout(dout_a[1]), .dout_vld(vld_a[1]), .busy(busy_a[1])
  );

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t        sb [2][$];
  logic [31:0] mdl [16];
  logic [31:0] last [2];
  int          init_cnt = 0;
  int          cyc = 0;
  int          nchk = 0;
  int          npass = 0;
  int          nacc = 0;
  int          nvld [2];
  int          ndisc [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (n & m) | (o & ~m);
  endfunction

  // Monitor: sampled 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (vld_a[k]) begin
        nvld[k]++;
        if (sb[k].size() == 0) begin
          chk("spurious_vld", k, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb[k].pop_front();
          chk("dout", k, dout_a[k], e.d);
          chk("latency_cycle", k, cyc, e.cyc);
          last[k] = dout_a[k];
        end
      end else begin
        if (sb[k].size() > 0 && sb[k][0].cyc <= cyc) begin
          exp_t e;
          e = sb[k].pop_front();
          chk("missing_vld", k, 32'd0, 32'd1);
        end
        if (rst) chk("dout_hold", k, dout_a[k], last[k]);
      end
      if (busy_a[k]) chk("vld_while_busy", k, {31'd0, vld_a[k]}, 32'd0);
    end
  end

  // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc_step(input bit w, input logic [3:0] b, input logic [3:0] aw,
                          input logic [31:0] d, input bit r, input logic [3:0] ar);
    wr = w; be = b; wa = aw; din = d; rd = r; ra = ar;
    for (int k = 0; k < 2; k++)
      chk("busy", k, {31'd0, busy_a[k]}, {31'd0, (init_cnt < 16)});
    if (init_cnt < 16) begin
      init_cnt++;
    end else begin
      if (r) begin
        logic [31:0] o;
        o = mdl[ar];
        sb[0].push_back('{o, cyc + 1});
        sb[1].push_back('{(w && aw == ar) ? lanes(o, d, b) : o, cyc + 2});
        nacc++;
      end
      if (w) mdl[aw] = lanes(mdl[aw], d, b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic chk_reset_state();
    for (int k = 0; k < 2; k++) begin
      chk("rst_dout", k, dout_a[k], 32'h0);
      chk("rst_vld", k, {31'd0, vld_a[k]}, 32'd0);
      chk("rst_busy", k, {31'd0, busy_a[k]}, 32'd1);
    end
  endtask

  task automatic release_reset();
    rst = 1'b1;
    init_cnt = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) cyc_step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; be = '0; wa = '0; din = '0; rd = 1'b0; ra = '0;
    for (int k = 0; k < 2; k++) begin
      last[k] = 32'h0; nvld[k] = 0; ndisc[k] = 0;
    end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state();

    // Init sweep; the write and read during busy must be ignored.
    release_reset();
    idle(5);
    cyc_step(1'b1, 4'hF, 4'd2, 32'hFFFF_FFFF, 1'b1, 4'd2);
    idle(10);
    read_all();

    // Latency and byte enables.
    cyc_step(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0);
    cyc_step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    idle(3);
    cyc_step(1'b1, 4'b0101, 4'd3, 32'h1122_3344, 1'b0, 4'd0);
    cyc_step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);

    // Collision on address 5, then back-to-back reads.
    cyc_step(1'b1, 4'hF, 4'd5, 32'hAAAA_AAAA, 1'b0, 4'd0);
    cyc_step(1'b1, 4'b0011, 4'd5, 32'h5555_5555, 1'b1, 4'd5);
    cyc_step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
    cyc_step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    idle(3);

    // Randomised traffic with frequent same-address collisions.
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] aw, ar;
      aw = 4'($urandom_range(15));
      ar = ($urandom_range(3) == 0) ? aw : 4'($urandom_range(15));
      cyc_step(1'($urandom_range(1)), 4'($urandom_range(15)), aw, $urandom,
               1'($urandom_range(1)), ar);
    end
    idle(3);

    // Reset between the read edge and the output-register edge.
    cyc_step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      ndisc[k] += sb[k].size();
      sb[k].delete();
      last[k] = 32'h0;
    end
    chk_reset_state();
    @(negedge clk);
    @(negedge clk);
    chk_reset_state();
    release_reset();
    idle(16);
    read_all();
    idle(4);

    for (int k = 0; k < 2; k++) begin
      chk("sb_empty", k, 32'(sb[k].size()), 32'd0);
      chk("vld_count", k, 32'(nvld[k]), 32'(nacc - ndisc[k]));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
